// File: rtl/voq_request_tracker_pkg.sv
// Shared switch parameters and bit-index helpers for the VOQ request tracker.
package voq_request_tracker_pkg;

    localparam int VOQ_N    = 12;  // switch ports
    localparam int VOQ_P    = 8;   // priority classes
    localparam int VOQ_LOGN = 4;   // port index width
    localparam int VOQ_LOGP = 3;   // class index width
    localparam int VOQ_CW   = 6;   // VOQ occupancy counter width
    localparam int VOQ_XFER = 4;   // busy cycles after a grant
    localparam int VOQ_TW   = 4;   // busy timer width

    // Request bit for VOQ(input j, class k, output i).
    function automatic int req_bit(input int j, input int k, input int i,
                                   input int n, input int p);
        return j * n * p + k * n + i;
    endfunction

    // Grant matrix bit for input j matched to output i.
    function automatic int grant_bit(input int j, input int i, input int n);
        return j * n + i;
    endfunction

endpackage

// File: rtl/voq_request_tracker_input_bank.sv
// One input port: N*P VOQ occupancy counters, registered request bits and
// the input-side busy timer. Grant validation for this input row lives here.
module voq_input_bank
    import voq_request_tracker_pkg::*;
#(
    parameter int N    = VOQ_N,
    parameter int P    = VOQ_P,
    parameter int LOGN = VOQ_LOGN,
    parameter int LOGP = VOQ_LOGP,
    parameter int CW   = VOQ_CW,
    parameter int XFER = VOQ_XFER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arr_valid,
    input  logic [LOGN-1:0] arr_dest,
    input  logic [LOGP-1:0] arr_pri,
    output logic            arr_ready,
    input  logic [N-1:0]    grant_row,
    input  logic [P-1:0]    grant_pri,
    input  logic [N-1:0]    out_idle,
    output logic [N-1:0]    grant_fire,
    output logic [N*P-1:0]  req,
    output logic            input_idle,
    output logic            err
);

    localparam int NP = N * P;
    localparam logic [CW-1:0]     CNT_MAX = '1;
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [VOQ_TW-1:0] T_ONE   = VOQ_TW'(1);

    logic [CW-1:0]     cnt_reg  [NP];
    logic [CW-1:0]     cnt_next [NP];
    logic [NP-1:0]     req_reg;
    logic [NP-1:0]     req_next;
    logic [NP-1:0]     arr_hit;
    logic [NP-1:0]     grant_hit;
    logic [NP-1:0]     cnt_full;
    logic [NP-1:0]     cnt_zero;
    logic [VOQ_TW-1:0] timer_reg;
    logic [VOQ_TW-1:0] timer_next;
    logic              arr_ok;
    logic              row_ok;
    logic              grant_ok;

    // Per-VOQ decode of the arrival/grant address and next counter value.
    // Element index is class*N + output, matching the request-bit layout.
    generate
        for (genvar gk = 0; gk < P; gk++) begin : g_class
            for (genvar gi = 0; gi < N; gi++) begin : g_out
                localparam int E = gk * N + gi;
                logic inc;
                logic dec;
                assign arr_hit[E]   = (arr_dest == LOGN'(gi)) && (arr_pri == LOGP'(gk));
                assign grant_hit[E] = grant_row[gi] & grant_pri[gk];
                assign cnt_full[E]  = (cnt_reg[E] == CNT_MAX);
                assign cnt_zero[E]  = (cnt_reg[E] == '0);
                assign inc          = arr_ok & arr_hit[E];
                assign dec          = grant_ok & grant_hit[E];
                // Simultaneous inc and dec cancel out.
                assign cnt_next[E]  = (inc && !dec) ? cnt_reg[E] + CNT_ONE :
                                      (dec && !inc) ? cnt_reg[E] - CNT_ONE :
                                                      cnt_reg[E];
                assign req_next[E]  = (cnt_next[E] != '0);
            end
        end
    endgenerate

    // Out-of-range destinations hit no counter, so they stay "ready" but are dropped.
    assign arr_ready  = !(|(arr_hit & cnt_full));
    assign arr_ok     = arr_valid && arr_ready && (|arr_hit);
    assign input_idle = (timer_reg == '0);

    // A grant is taken only when well-formed, the VOQ holds a cell and both ends are idle.
    assign row_ok     = $onehot(grant_row) && $onehot(grant_pri);
    assign grant_ok   = row_ok && input_idle && (|(grant_row & out_idle))
                        && !(|(grant_hit & cnt_zero));
    assign grant_fire = grant_ok ? grant_row : '0;
    assign err        = (arr_valid && !arr_ok) || ((|grant_row) && !grant_ok);
    assign req        = req_reg;

    // Input busy timer: reload on an accepted grant, otherwise count down to zero.
    always_comb begin
        timer_next = timer_reg;
        if (grant_ok) begin
            timer_next = VOQ_TW'(XFER);
        end else if (timer_reg != '0) begin
            timer_next = timer_reg - T_ONE;
        end
    end

    // Counter, request and timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < NP; e++) begin
                cnt_reg[e] <= '0;
            end
            req_reg   <= '0;
            timer_reg <= '0;
        end else begin
            for (int e = 0; e < NP; e++) begin
                cnt_reg[e] <= cnt_next[e];
            end
            req_reg   <= req_next;
            timer_reg <= timer_next;
        end
    end

endmodule

// File: rtl/voq_request_tracker.sv
// VOQ request tracker: per-input counter banks, output busy timers and a
// sticky protocol-error flag.
module voq_request_tracker
    import voq_request_tracker_pkg::*;
#(
    parameter int N    = VOQ_N,
    parameter int P    = VOQ_P,
    parameter int LOGN = VOQ_LOGN,
    parameter int LOGP = VOQ_LOGP,
    parameter int CW   = VOQ_CW,
    parameter int XFER = VOQ_XFER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     i_arr_valid,
    input  logic [N*LOGN-1:0] i_arr_dest,
    input  logic [N*LOGP-1:0] i_arr_pri,
    output logic [N-1:0]     o_arr_ready,
    input  logic [N*N-1:0]   i_acc_grant,
    input  logic [N*P-1:0]   i_acc_priority,
    output logic [N*N*P-1:0] o_priority,
    output logic [N-1:0]     o_input_idle,
    output logic [N-1:0]     o_output_idle,
    output logic             o_err
);

    localparam logic [VOQ_TW-1:0] T_ONE = VOQ_TW'(1);

    logic [N*N-1:0]    fire_flat;
    logic [N-1:0]      out_load;
    logic [N-1:0]      bank_err;
    logic [VOQ_TW-1:0] out_timer_reg [N];
    logic              err_reg;

    generate
        for (genvar gj = 0; gj < N; gj++) begin : g_in
            voq_input_bank #(
                .N    (N),
                .P    (P),
                .LOGN (LOGN),
                .LOGP (LOGP),
                .CW   (CW),
                .XFER (XFER)
            ) u_bank (
                .clk        (clk),
                .reset      (reset),
                .arr_valid  (i_arr_valid[gj]),
                .arr_dest   (i_arr_dest[gj*LOGN +: LOGN]),
                .arr_pri    (i_arr_pri[gj*LOGP +: LOGP]),
                .arr_ready  (o_arr_ready[gj]),
                .grant_row  (i_acc_grant[grant_bit(gj, 0, N) +: N]),
                .grant_pri  (i_acc_priority[gj*P +: P]),
                .out_idle   (o_output_idle),
                .grant_fire (fire_flat[grant_bit(gj, 0, N) +: N]),
                .req        (o_priority[req_bit(gj, 0, 0, N, P) +: N*P]),
                .input_idle (o_input_idle[gj]),
                .err        (bank_err[gj])
            );
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_out_idle
            assign o_output_idle[gi] = (out_timer_reg[gi] == '0);
        end
    endgenerate

    // An output timer reloads when any input's accepted grant targets it.
    always_comb begin
        out_load = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                out_load[i] = out_load[i] | fire_flat[j*N + i];
            end
        end
    end

    // Output busy timers and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                out_timer_reg[i] <= '0;
            end
            err_reg <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (out_load[i]) begin
                    out_timer_reg[i] <= VOQ_TW'(XFER);
                end else if (out_timer_reg[i] != '0) begin
                    out_timer_reg[i] <= out_timer_reg[i] - T_ONE;
                end
            end
            err_reg <= err_reg | (|bank_err);
        end
    end

    assign o_err = err_reg;

endmodule

// File: tb/tb_voq_request_tracker.sv
// Self-checking bench: table of single-cycle vectors with hand-derived
// expectations, a cycle scoreboard fed by a reference model, and a few
// multi-cycle sequences for the timer, saturation and reset corners.
module tb_voq_request_tracker;
    import voq_request_tracker_pkg::*;

    localparam int N    = VOQ_N;
    localparam int P    = VOQ_P;
    localparam int LOGN = VOQ_LOGN;
    localparam int LOGP = VOQ_LOGP;
    localparam int CW   = VOQ_CW;
    localparam int XFER = VOQ_XFER;
    localparam int NNP  = N * N * P;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk;
    logic             reset;
    logic [N-1:0]     i_arr_valid;
    logic [N*LOGN-1:0] i_arr_dest;
    logic [N*LOGP-1:0] i_arr_pri;
    logic [N-1:0]     o_arr_ready;
    logic [N*N-1:0]   i_acc_grant;
    logic [N*P-1:0]   i_acc_priority;
    logic [NNP-1:0]   o_priority;
    logic [N-1:0]     o_input_idle;
    logic [N-1:0]     o_output_idle;
    logic             o_err;

    voq_request_tracker #(
        .N(N), .P(P), .LOGN(LOGN), .LOGP(LOGP), .CW(CW), .XFER(XFER)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_arr_valid    (i_arr_valid),
        .i_arr_dest     (i_arr_dest),
        .i_arr_pri      (i_arr_pri),
        .o_arr_ready    (o_arr_ready),
        .i_acc_grant    (i_acc_grant),
        .i_acc_priority (i_acc_priority),
        .o_priority     (o_priority),
        .o_input_idle   (o_input_idle),
        .o_output_idle  (o_output_idle),
        .o_err          (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_cnt [NNP];
    int m_it  [N];
    int m_ot  [N];
    bit m_err;

    typedef struct {
        logic [NNP-1:0] pri;
        logic [N-1:0]   iidle;
        logic [N-1:0]   oidle;
        logic           err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit rst;
        bit av;  int aj; int ad; int ap;
        bit gv;  int gj; int gi; int gk;
        bit gdbl;
        int chk_bit; bit chk_val; bit chk_err;
    } vec_t;
    vec_t vt [9];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_arr_valid    = '0;
        i_arr_dest     = '0;
        i_arr_pri      = '0;
        i_acc_grant    = '0;
        i_acc_priority = '0;
    endtask

    task automatic set_arr(input int j, input int d, input int p);
        i_arr_valid[j]            = 1'b1;
        i_arr_dest[j*LOGN +: LOGN] = d[LOGN-1:0];
        i_arr_pri[j*LOGP +: LOGP]  = p[LOGP-1:0];
    endtask

    task automatic set_grant(input int j, input int i, input int k);
        i_acc_grant[j*N + i]    = 1'b1;
        i_acc_priority[j*P + k] = 1'b1;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit inc [NNP];
        bit dec [NNP];
        int nit [N];
        int nott [N];
        int d, p, idx, gi_, gk_;
        logic [N-1:0] row;
        logic [P-1:0] pr;
        if (reset) begin
            for (int e = 0; e < NNP; e++) m_cnt[e] = 0;
            for (int n = 0; n < N; n++) begin m_it[n] = 0; m_ot[n] = 0; end
            m_err = 1'b0;
            return;
        end
        for (int e = 0; e < NNP; e++) begin inc[e] = 0; dec[e] = 0; end
        for (int n = 0; n < N; n++) begin
            nit[n]  = (m_it[n] > 0) ? m_it[n] - 1 : 0;
            nott[n] = (m_ot[n] > 0) ? m_ot[n] - 1 : 0;
        end
        for (int j = 0; j < N; j++) begin
            if (i_arr_valid[j]) begin
                d = int'(i_arr_dest[j*LOGN +: LOGN]);
                p = int'(i_arr_pri[j*LOGP +: LOGP]);
                if (d >= N || p >= P) m_err = 1'b1;
                else begin
                    idx = j*N*P + p*N + d;
                    if (m_cnt[idx] == CMAX) m_err = 1'b1;
                    else inc[idx] = 1'b1;
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            row = i_acc_grant[j*N +: N];
            pr  = i_acc_priority[j*P +: P];
            if (row != '0) begin
                if ($countones(row) != 1 || $countones(pr) != 1) m_err = 1'b1;
                else begin
                    gi_ = 0; gk_ = 0;
                    for (int n = 0; n < N; n++) if (row[n]) gi_ = n;
                    for (int n = 0; n < P; n++) if (pr[n]) gk_ = n;
                    idx = j*N*P + gk_*N + gi_;
                    if (m_cnt[idx] == 0 || m_it[j] != 0 || m_ot[gi_] != 0) m_err = 1'b1;
                    else begin
                        dec[idx]  = 1'b1;
                        nit[j]    = XFER;
                        nott[gi_] = XFER;
                    end
                end
            end
        end
        for (int e = 0; e < NNP; e++) begin
            if (inc[e] && !dec[e]) m_cnt[e]++;
            else if (dec[e] && !inc[e]) m_cnt[e]--;
        end
        for (int n = 0; n < N; n++) begin m_it[n] = nit[n]; m_ot[n] = nott[n]; end
    endtask

    // One clock: check combinational ready, queue the model's expectation,
    // clock, then pop and compare against the registered outputs.
    task automatic tick();
        exp_t ex;
        exp_t got;
        logic [N-1:0] rdy_exp;
        int d, p;
        #1;
        if (!reset) begin
            for (int j = 0; j < N; j++) begin
                d = int'(i_arr_dest[j*LOGN +: LOGN]);
                p = int'(i_arr_pri[j*LOGP +: LOGP]);
                rdy_exp[j] = !(d < N && p < P && m_cnt[j*N*P + p*N + d] == CMAX);
            end
            chk("arr_ready", 1024'(o_arr_ready), 1024'(rdy_exp));
        end
        model_step();
        for (int e = 0; e < NNP; e++) ex.pri[e] = (m_cnt[e] != 0);
        for (int n = 0; n < N; n++) begin
            ex.iidle[n] = (m_it[n] == 0);
            ex.oidle[n] = (m_ot[n] == 0);
        end
        ex.err = m_err;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        cyc++;
        got = sb_q.pop_front();
        chk("sb_priority",    1024'(o_priority),    1024'(got.pri));
        chk("sb_input_idle",  1024'(o_input_idle),  1024'(got.iidle));
        chk("sb_output_idle", 1024'(o_output_idle), 1024'(got.oidle));
        chk("sb_err",         1024'(o_err),         1024'(got.err));
    endtask

    initial begin
        // rst av aj ad ap gv gj gi gk dbl bit val err
        vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 233, 0, 0};
        vt[1] = '{0, 1, 2, 5, 3, 0, 0, 0, 0, 0, 233, 1, 0};
        vt[2] = '{0, 0, 0, 0, 0, 1, 2, 5, 3, 0, 233, 0, 0};
        vt[3] = '{0, 1, 1, 11, 7, 0, 0, 0, 0, 0, 191, 1, 0};
        vt[4] = '{0, 1, 1, 11, 7, 0, 0, 0, 0, 0, 191, 1, 0};
        vt[5] = '{0, 1, 1, 11, 7, 1, 1, 11, 7, 0, 191, 1, 0};
        vt[6] = '{0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 384, 0, 1};
        vt[7] = '{0, 0, 0, 0, 0, 1, 1, 11, 7, 0, 191, 1, 1};
        vt[8] = '{0, 0, 0, 0, 0, 1, 3, 3, 0, 0, 291, 0, 1};

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Table-driven single-cycle vectors
        for (int v = 0; v < 9; v++) begin
            clear_inputs();
            reset = vt[v].rst;
            if (vt[v].av) set_arr(vt[v].aj, vt[v].ad, vt[v].ap);
            if (vt[v].gv) set_grant(vt[v].gj, vt[v].gi, vt[v].gk);
            if (vt[v].gdbl) i_acc_grant[vt[v].gj*N + vt[v].gi + 1] = 1'b1;
            tick();
            chk($sformatf("vec%0d_req", v), 1024'(o_priority[vt[v].chk_bit]), 1024'(vt[v].chk_val));
            chk($sformatf("vec%0d_err", v), 1024'(o_err), 1024'(vt[v].chk_err));
            $display("vec %0d applied: bit %0d=%0b err=%0b", v, vt[v].chk_bit, o_priority[vt[v].chk_bit], o_err);
        end
        clear_inputs();
        reset = 1'b0;

        // Busy window after a grant, and a grant accepted the cycle idle returns
        clear_inputs(); reset = 1'b1; tick(); reset = 1'b0;
        set_arr(2, 5, 3); tick(); tick(); clear_inputs();
        set_grant(2, 5, 3); tick(); clear_inputs();
        chk("busy0_in_idle",  1024'(o_input_idle[2]),  1024'(0));
        chk("busy0_out_idle", 1024'(o_output_idle[5]), 1024'(0));
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk($sformatf("busy%0d_in_idle", t),  1024'(o_input_idle[2]),  1024'(t >= 4));
            chk($sformatf("busy%0d_out_idle", t), 1024'(o_output_idle[5]), 1024'(t >= 4));
        end
        set_grant(2, 5, 3); tick(); clear_inputs();
        chk("regrant_err",     1024'(o_err),           1024'(0));
        chk("regrant_in_idle", 1024'(o_input_idle[2]), 1024'(0));
        chk("regrant_req",     1024'(o_priority[233]), 1024'(0));
        $display("busy window sequence done");

        // Counter saturation at 63 then drain by exactly 63 grants
        reset = 1'b1; tick(); reset = 1'b0;
        for (int a = 0; a < CMAX; a++) begin
            set_arr(0, 0, 0); tick(); clear_inputs();
        end
        set_arr(0, 0, 0);
        #1;
        chk("sat_ready", 1024'(o_arr_ready[0]), 1024'(0));
        tick(); clear_inputs();
        chk("sat_err", 1024'(o_err), 1024'(1));
        for (int g = 0; g < CMAX; g++) begin
            set_grant(0, 0, 0); tick(); clear_inputs();
            if (g == CMAX - 2) chk("drain62_req", 1024'(o_priority[0]), 1024'(1));
            for (int w = 0; w < XFER; w++) tick();
        end
        chk("drain63_req", 1024'(o_priority[0]), 1024'(0));
        $display("saturation sequence done");

        // Reset in the middle of a transfer with arrivals pending
        reset = 1'b1; tick(); reset = 1'b0;
        set_arr(6, 9, 2); tick(); clear_inputs();
        set_arr(6, 9, 2); set_grant(6, 9, 2); tick(); clear_inputs();
        i_acc_grant[7*N + 0] = 1'b1; i_acc_grant[7*N + 1] = 1'b1; i_acc_priority[7*P] = 1'b1;
        tick(); clear_inputs();
        chk("pre_rst_err",  1024'(o_err), 1024'(1));
        chk("pre_rst_idle", 1024'(o_input_idle[6]), 1024'(0));
        set_arr(6, 9, 2); set_arr(3, 1, 4); set_grant(6, 9, 2); reset = 1'b1;
        tick(); clear_inputs(); reset = 1'b0;
        chk("rst_priority", 1024'(o_priority),    1024'(0));
        chk("rst_in_idle",  1024'(o_input_idle),  1024'({N{1'b1}}));
        chk("rst_out_idle", 1024'(o_output_idle), 1024'({N{1'b1}}));
        chk("rst_err",      1024'(o_err),         1024'(0));
        #1;
        chk("rst_ready", 1024'(o_arr_ready), 1024'({N{1'b1}}));
        tick();
        $display("mid-transfer reset sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
